// File: rtl/comperator_axi_ip_v1_0_block_writer_pkg.sv
// Shared types and helpers for the comperator block writer and its siblings.
package comperator_axi_ip_v1_0_block_writer_pkg;

  localparam int DATA_WIDTH = 24;

  // Same encodings as the block reader so state dumps read identically.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  // A zero or oversize length means "send the whole block".
  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] block_size);
    logic [15:0] r;
    r = len;
    if ((len == 16'd0) || (len > block_size)) r = block_size;
    return r;
  endfunction

endpackage

// File: rtl/comperator_axi_ip_v1_0_frame_position.sv
// Tracks the column/row of the next pixel in a video frame.
module comperator_axi_ip_v1_0_frame_position #(
  parameter int LINE_WIDTH = 640,
  parameter int LINE_COUNT = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] col,
  output logic [15:0] row,
  output logic        sof,
  output logic        eol
);

  // Step one pixel per advance strobe, wrapping at line and frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= 16'd0;
      row <= 16'd0;
    end else if (advance) begin
      if (col == 16'(LINE_WIDTH - 1)) begin
        col <= 16'd0;
        row <= (row == 16'(LINE_COUNT - 1)) ? 16'd0 : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  assign sof = (col == 16'd0) && (row == 16'd0);
  assign eol = (col == 16'(LINE_WIDTH - 1));

endmodule

// File: rtl/comperator_axi_ip_v1_0_block_writer.sv
// Serialises a parallel pixel block onto an AXI4-Stream video master.
module comperator_axi_ip_v1_0_block_writer
  import comperator_axi_ip_v1_0_block_writer_pkg::*;
#(
  parameter int BLOCK_SIZE = 8,
  parameter int LINE_WIDTH = 640,
  parameter int LINE_COUNT = 480
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             go,
  input  logic [15:0]                      len,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] block,
  output logic                             done
);

  localparam int BLOCK_W = BLOCK_SIZE * DATA_WIDTH;

  state_t             state;
  state_t             state_nx;
  logic [BLOCK_W-1:0] shift_q;
  logic [15:0]        remaining;
  logic               handshake;
  logic               accept;
  logic [15:0]        col;
  logic [15:0]        row;
  logic               sof;
  logic               eol;

  assign handshake = m_axis_tvalid & m_axis_tready;
  // go is only honoured between blocks; a block in flight is never disturbed.
  assign accept    = go && (state != SEND);

  // Next-state logic: load on accepted go, finish on the last handshake.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (go) state_nx = SEND;
      SEND:       if (handshake && (remaining == 16'd1)) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // Block shift register and beat counter; zero-fill keeps leftovers harmless.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shift_q   <= '0;
      remaining <= 16'd0;
    end else if (accept) begin
      shift_q   <= block;
      remaining <= clamp_len(len, 16'(BLOCK_SIZE));
    end else if (handshake) begin
      shift_q   <= shift_q << DATA_WIDTH;
      remaining <= remaining - 16'd1;
    end
  end

  // Position persists across blocks so tuser/tlast follow the frame, not the block.
  comperator_axi_ip_v1_0_frame_position #(
    .LINE_WIDTH(LINE_WIDTH),
    .LINE_COUNT(LINE_COUNT)
  ) u_pos (
    .clk    (aclk),
    .rst_n  (aresetn),
    .advance(handshake),
    .col    (col),
    .row    (row),
    .sof    (sof),
    .eol    (eol)
  );

  // Position counters must never leave the frame.
  pos_in_range: assert property (@(posedge aclk) disable iff (!aresetn)
    (col < 16'(LINE_WIDTH)) && (row < 16'(LINE_COUNT)));

  // All outputs derive only from registers, so they hold while tready is low.
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = shift_q[BLOCK_W-1 -: DATA_WIDTH];
  assign m_axis_tuser  = m_axis_tvalid & sof;
  assign m_axis_tlast  = m_axis_tvalid & eol;
  assign done          = (state == DONE);

endmodule

// File: tb/tb_comperator_axi_ip_v1_0_block_writer.sv
// Scoreboard bench: two writers (12-wide lines, and a 4x2 frame) share stimulus.
module tb_comperator_axi_ip_v1_0_block_writer;

  localparam int BS = 8;
  localparam int BW = BS * 24;
  localparam int LW_A = 12;
  localparam int LC_A = 480;
  localparam int LW_B = 4;
  localparam int LC_B = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          go = 1'b0;
  logic          tready = 1'b1;
  logic [15:0]   len = 16'd0;
  logic [BW-1:0] block = '0;

  logic [23:0] tdata_a, tdata_b;
  logic        tlast_a, tlast_b, tuser_a, tuser_b, tvalid_a, tvalid_b, done_a, done_b;

  always #5 aclk = ~aclk;

  comperator_axi_ip_v1_0_block_writer #(.BLOCK_SIZE(BS), .LINE_WIDTH(LW_A), .LINE_COUNT(LC_A)) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .m_axis_tdata(tdata_a), .m_axis_tlast(tlast_a), .m_axis_tready(tready),
    .m_axis_tuser(tuser_a), .m_axis_tvalid(tvalid_a),
    .go(go), .len(len), .block(block), .done(done_a)
  );

  comperator_axi_ip_v1_0_block_writer #(.BLOCK_SIZE(BS), .LINE_WIDTH(LW_B), .LINE_COUNT(LC_B)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .m_axis_tdata(tdata_b), .m_axis_tlast(tlast_b), .m_axis_tready(tready),
    .m_axis_tuser(tuser_b), .m_axis_tvalid(tvalid_b),
    .go(go), .len(len), .block(block), .done(done_b)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        su_a;
    logic        tl_a;
    logic        su_b;
    logic        tl_b;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      mon_e;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         hs_count = 0;
  int         last_hs = 0;
  int         beat_idx = 0;
  logic       toggle_en = 1'b0;
  logic [3:0] pat = 4'b1001;
  logic [1:0] pidx = 2'd0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] mk_block(input logic [23:0] base);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < BS; k++) r[BW-1-24*k -: 24] = base + 24'(k);
    return r;
  endfunction

  // Expected beats with hand-derived frame flags from the global beat index.
  task automatic push_beats(input logic [BW-1:0] blk, input int n);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.data = blk[BW-1-24*k -: 24];
      e.su_a = (beat_idx % (LW_A * LC_A)) == 0;
      e.tl_a = (beat_idx % LW_A) == (LW_A - 1);
      e.su_b = (beat_idx % (LW_B * LC_B)) == 0;
      e.tl_b = (beat_idx % LW_B) == (LW_B - 1);
      exp_q.push_back(e);
      beat_idx++;
    end
  endtask

  // Monitor: every presented beat must match the queue front, held or accepted.
  always @(negedge aclk) begin
    if (aresetn && (tvalid_a || tvalid_b)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got tdata %h with no expected beat", tdata_a);
      end else begin
        mon_e = exp_q[0];
        chk("tvalid_a", 32'(tvalid_a), 32'd1);
        chk("tvalid_b", 32'(tvalid_b), 32'd1);
        chk("tdata_a", 32'(tdata_a), 32'(mon_e.data));
        chk("tdata_b", 32'(tdata_b), 32'(mon_e.data));
        chk("tuser_a", 32'(tuser_a), 32'(mon_e.su_a));
        chk("tlast_a", 32'(tlast_a), 32'(mon_e.tl_a));
        chk("tuser_b", 32'(tuser_b), 32'(mon_e.su_b));
        chk("tlast_b", 32'(tlast_b), 32'(mon_e.tl_b));
        if (tready) begin
          void'(exp_q.pop_front());
          hs_count++;
          last_hs = cyc + 1;
        end
      end
    end
  end

  // Backpressure source: constant ready, or the repeating 1,0,0,1 pattern.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (toggle_en) begin
        tready = pat[pidx];
        pidx = pidx + 2'd1;
      end else begin
        tready = 1'b1;
      end
    end
  end

  task automatic send_block(input logic [23:0] base, input logic [15:0] l, input int n_exp,
                            input bit const_ready, input bit glitch_go);
    int hs0;
    int go_cyc;
    int done_cyc;
    bit seen;
    block = mk_block(base);
    len = l;
    push_beats(block, n_exp);
    hs0 = hs_count;
    done_cyc = 0;
    @(posedge aclk);
    #1;
    go = 1'b1;
    go_cyc = cyc + 1;
    @(posedge aclk);
    #1;
    go = 1'b0;
    if (glitch_go) begin
      block = mk_block(24'hBAD000);
      len = 16'd8;
      go = 1'b1;
      @(posedge aclk);
      #1;
      go = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (done_a) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: done never rose for block %h, required within 200 cycles", base);
    end else begin
      chk("done_after_last_beat", 32'(done_cyc), 32'(last_hs));
      if (const_ready) chk("block_latency", 32'(done_cyc), 32'(go_cyc + n_exp));
      chk("handshakes", 32'(hs_count - hs0), 32'(n_exp));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("tvalid_low_in_done", 32'(tvalid_a), 32'd0);
      chk("done_b", 32'(done_b), 32'd1);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tvalid_a"}, 32'(tvalid_a), 32'd0);
    chk({tag, "_tdata_a"}, 32'(tdata_a), 32'd0);
    chk({tag, "_tuser_a"}, 32'(tuser_a), 32'd0);
    chk({tag, "_tlast_a"}, 32'(tlast_a), 32'd0);
    chk({tag, "_done_a"}, 32'(done_a), 32'd0);
    chk({tag, "_tvalid_b"}, 32'(tvalid_b), 32'd0);
    chk({tag, "_tdata_b"}, 32'(tdata_b), 32'd0);
    chk({tag, "_done_b"}, 32'(done_b), 32'd0);
  endtask

  initial begin
    int hs0;
    bit reached;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    chk_idle_outputs("reset");

    // Full block, pixels 1..8, constant ready.
    send_block(24'h000001, 16'd8, 8, 1'b1, 1'b0);
    // Same block under 1,0,0,1 backpressure; straddles the 12-pixel line.
    toggle_en = 1'b1;
    send_block(24'h000001, 16'd8, 8, 1'b0, 1'b0);
    toggle_en = 1'b0;
    // Short block, then len=0 meaning a full block.
    send_block(24'h100000, 16'd3, 3, 1'b1, 1'b0);
    send_block(24'h200000, 16'd0, 8, 1'b1, 1'b0);
    // Oversize length clamps to the block size.
    send_block(24'h280000, 16'd20, 8, 1'b1, 1'b0);

    // Reset after three beats of a block.
    block = mk_block(24'h300000);
    len = 16'd8;
    push_beats(block, 8);
    hs0 = hs_count;
    @(posedge aclk);
    #1 go = 1'b1;
    @(posedge aclk);
    #1 go = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (hs_count >= hs0 + 3) begin
        reached = 1'b1;
        break;
      end
      @(posedge aclk);
    end
    if (!reached) begin
      checks++;
      failures++;
      $display("FAIL midblock_wait: got %0d beats, required 3", hs_count - hs0);
    end
    #2 aresetn = 1'b0;
    #1 chk_idle_outputs("async_reset");
    exp_q.delete();
    beat_idx = 0;
    @(posedge aclk);
    #2 aresetn = 1'b1;

    // Three blocks of 4 from a fresh frame; a go during the first is ignored.
    send_block(24'h400000, 16'd4, 4, 1'b1, 1'b1);
    send_block(24'h500000, 16'd4, 4, 1'b1, 1'b0);
    send_block(24'h600000, 16'd4, 4, 1'b1, 1'b0);

    repeat (4) @(negedge aclk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_tvalid", 32'(tvalid_a), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comperator_axi_ip_v1_0_block_writer.md
# comperator_axi_ip_v1_0_block_writer

Serialises one parallel block of up to BLOCK_SIZE 24-bit pixels onto an AXI4-Stream video master, one pixel per handshake. This is the transmit counterpart of the comperator block reader: the comparator core hands it a result block plus a length and pulses `go`. The writer then drives the output frame, generating `tuser` (start of frame) and `tlast` (end of line) from its own line/frame position counters. The output frame feeds the downstream VDMA/video-out path.

## Interface
- BLOCK_SIZE, 8: maximum pixels per block.
- LINE_WIDTH, 640: pixels per line; `tlast` asserts on the last pixel of each line.
- LINE_COUNT, 480: lines per frame; `tuser` asserts on pixel (0,0).
- aclk  in  1  single clock; all logic on its rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- m_axis_tdata  out  24  pixel data.
- m_axis_tlast  out  1  last pixel of line.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tvalid  out  1  pixel valid.
- go  in  1  load `block`/`len` and start sending; accepted only in IDLE or DONE.
- len  in  16  number of pixels to send; 0 or >BLOCK_SIZE means BLOCK_SIZE.
- block  in  BLOCK_SIZE*24  pixels; the first pixel sent is bits [BLOCK_SIZE*24-1 -: 24].
- done  out  1  level; high in DONE until the next accepted `go`.

## Operation
- States: IDLE (after reset), SEND, DONE.
- IDLE/DONE with `go`=1:
  - Capture `block` into a shift register.
  - Capture the clamped `len` into `remaining`.
  - Next state is SEND.
- `go` while in SEND is ignored. The latched block and `len` are not disturbed.
- SEND:
  - `m_axis_tvalid`=1 and `m_axis_tdata` = shift register top 24 bits.
  - Handshake (`tvalid` & `tready`): shift left by 24, zero-fill, `remaining`−1, advance position.
  - Handshake with `remaining`==1 → DONE.
- Position counters:
  - `col` 16 bit, 0..LINE_WIDTH−1; `row` 16 bit, 0..LINE_COUNT−1.
  - Advance only on handshake. `col` wraps to 0 and increments `row`; `row` wraps to 0 after LINE_COUNT−1.
  - Counters persist across blocks. A block may straddle a line or frame boundary; `tlast`/`tuser` follow position, not block edges.
- `m_axis_tuser` = (`col`==0 && `row`==0).
- `m_axis_tlast` = (`col`==LINE_WIDTH−1).
- `tuser`, `tlast` and `tdata` are registered and consistent with the pixel currently presented.
- AXI rule: once `tvalid` is high, `tvalid`, `tdata`, `tuser` and `tlast` stay stable until the handshake completes. There is no dependency of `tvalid` on `tready`.
- Reset (any time, including mid-block):
  - Outputs go to 0 immediately: `tvalid`, `tdata`, `tuser`, `tlast`, `done`.
  - State → IDLE; `col`, `row`, `remaining` and the shift register → 0.
  - The next pixel sent is frame pixel (0,0) with `tuser`=1.

## Timing
- `go` sampled at edge N → `tvalid`=1 with the first pixel after N. `done` falls after N if it was high.
- Throughput: 1 pixel/cycle while `tready`=1. A block of L pixels with constant `tready` occupies cycles N+1..N+L.
- The last handshake at edge K gives, after K: `tvalid`=0 and `done`=1.
- `go` asserted in the same cycle `done` is first visible → the next block starts one cycle later. Back-to-back blocks therefore have a 1-cycle `tvalid` bubble.
- `tready` low holds all outputs; counters do not advance.

## Structure
- Shared package/header holds:
  - DATA_WIDTH=24.
  - State encodings IDLE=2'b00, SEND=2'b01, DONE=2'b10, shared with the reader's naming.
  - A `len`-clamp function.
- Natural sub-module `comperator_axi_ip_v1_0_frame_position`:
  - Inputs: clock, reset, advance strobe.
  - Outputs: `col`, `row`, `sof` (start of frame), `eol` (end of line).
  - Parameters: LINE_WIDTH, LINE_COUNT.
  - Reusable later for frame-level checks on the reader side.

## Test plan
- Reset, BLOCK_SIZE=8, `block` = pixels 0x000001..0x000008 (0x000001 at top), `len`=8, `go` pulse, `tready`=1 → 8 beats 0x000001..0x000008 on consecutive cycles. First beat has `tuser`=1 and no `tlast`; `done`=1 the cycle after the 8th beat.
- Same block with `tready` toggling 1,0,0,1,… → identical data sequence; outputs frozen while `tready`=0; exactly 8 handshakes.
- `len`=3 then `len`=0 → first block sends 3 beats and then `done`; second block sends 8 beats.
- LINE_WIDTH=12, two 8-pixel blocks → `tlast` on beat 12 (the 4th beat of block 2). The following beat restarts at `col` 0 with no `tuser` (row 1).
- LINE_WIDTH=4, LINE_COUNT=2, three blocks of 4 → `tuser` on beats 1 and 9; `tlast` on beats 4, 8 and 12.
- `aresetn` low mid-block after 3 beats → outputs 0 asynchronously. Then a new `go` → first beat has `tuser`=1 and `done` behaves normally; a `go` issued during SEND is ignored.
